alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Multi-cycle fetch/decode/execute controller for the 9-bit RISC CPU; it drives the ALU's rsh/ci/op/in_a/in_b inputs and consumes its rslt/co/z outputs.
- Owns the PC, instruction register and flag registers, and sequences the instruction memory, register file and data-memory store port.
- Each instruction takes 4 cycles; HLT stops execution until the next start pulse.

Parameters:
- PC_W, 8, PC / instruction-memory address width.
- RST_PC, 0, PC value after reset and on each start pulse.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins execution from RST_PC when IDLE or HALT.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.
- done  out  1  high while in HALT.
- imem_addr  out  PC_W  instruction address; synchronous ROM with 1-cycle read latency.
- imem_data  in  9  instruction word.
- rf_ra_addr, rf_rb_addr  out  3  register-file read addresses; reads are combinational.
- rf_a_data, rf_b_data  in  8  register-file read data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  3  register-file write address.
- rf_wdata  out  8  register-file write data.
- alu_op  out  3  ALU opcode.
- alu_rsh  out  1  ALU shift direction (1 = right).
- alu_ci  out  1  ALU carry in.
- alu_a, alu_b  out  8  ALU operands.
- alu_rslt  in  8  ALU result.
- alu_co  in  1  ALU carry out.
- alu_z  in  1  ALU zero flag.
- dmem_we  out  1  store strobe.
- dmem_addr, dmem_wdata  out  8  store address / data.

Behaviour:
- Opcode encoding, IR[8:6]: kADD=000, kAND=001, kXOR=010, kLSH=011, kSTR=100, kLDI=101, kBNE=110, kHLT=111.
- ADD/AND/XOR: ra=IR[5:3], rb=IR[2:0]; R[ra] <= alu(R[ra], R[rb]).
- LSH: ra=IR[5:3]; alu_rsh=IR[2]; alu_b={6'b0,IR[1:0]}; R[ra] <= shifted R[ra].
- STR: dmem[R[rb]] <= R[ra]; alu_a=R[ra]; the ALU pass-through result drives dmem_wdata.
- LDI: alu_b={2'b0,IR[5:0]}; R0 <= imm6 (0..63) via the ALU pass-through.
- BNE: alu_a=R0, alu_b=R1. If the latched z==0, PC <= PC_of_BNE + sext(IR[5:0]); otherwise PC <= PC+1.
- HLT: go to HALT; PC is frozen at the HLT address.
- States and transitions:
  - IDLE -start-> FETCH.
  - FETCH -> DECODE: imem_addr=PC.
  - DECODE -> EXEC: IR <= imem_data; rf read addresses driven from IR.
  - EXEC -> WB: ALU inputs driven; result, co and z latched into res_q, c_flag, z_q.
  - WB -> FETCH, or WB -> HALT on HLT: rf_we or dmem_we pulses for exactly 1 cycle; PC updated.
  - HALT -start-> FETCH with PC=RST_PC.
- Latency: 4 cycles per instruction, measured from FETCH entry to the next FETCH entry.
- ALU outputs are consumed in the same cycle as the ALU inputs are driven (combinational ALU).
- c_flag updates on ADD only. z_q is used only by BNE.
- Arithmetic: 8-bit data wraps modulo 256. PC arithmetic wraps modulo 2^PC_W; offset 0 gives a self-loop, which is legal.
- Reset (rst_n=0 at a clock edge, including mid-instruction):
  - state=IDLE, PC=RST_PC, IR=0, flags=0.
  - All outputs 0: busy, done, rf_we, dmem_we, addresses, data, alu_*.
  - Any pending write is dropped.
- start while busy is ignored.
- start and rst_n=0 in the same cycle: reset wins.
- Outside EXEC, alu_* outputs hold 0. rf_we and dmem_we are never high together.

Optional Feature:
- Macro ALU_CTRL_ADC_EN.
- Defined: ADD drives alu_ci=c_flag (add-with-carry chaining), and c_flag is cleared on start.
- Undefined: alu_ci is tied to 0 and c_flag is still tracked.

Decomposition:
- Existing package `definitions` gains:
  - kHLT=3'b111;
  - state enum (IDLE, FETCH, DECODE, EXEC, WB, HALT);
  - IR field-position constants;
  - an imm6 sign-extend function.
- Sub-module instr_decode: combinational IR -> {alu_op, rsh, operand selects, rf_we_req, dmem_we_req, is_bne, is_hlt}. Instantiated once.

Test Plan:
- Reset mid-instruction: assert rst_n=0 in EXEC -> next cycle IDLE, PC=0, all strobes 0; no rf write for that instruction.
- Program "LDI 23; ADD R0,R1" with R1=22, then HLT -> R0=45 written in the WB of the ADD; done=1 twelve cycles after FETCH entry; busy low after that.
- ADD with R0=255, R1=4 -> R0=3 and c_flag=1.
  - With ALU_CTRL_ADC_EN, a following ADD with R0=1, R1=1 drives alu_ci=1 and gives R0=3.
  - Without it, the same ADD gives R0=2.
- LSH with R2=16, IR[2]=0, IR[1:0]=2 -> R2=64. Then R2=16 with IR[2]=1 -> R2=4; alu_rsh seen high in EXEC.
- BNE offset -2 at PC=5:
  - R0=58, R1=56 -> next imem_addr=3.
  - R0=R1=56 -> next imem_addr=6.
  - Offset reaching past PC=255 wraps to a low address.
- STR with R3=16, R4=2 -> exactly one cycle of dmem_we=1 with dmem_addr=2, dmem_wdata=16; rf_we stays 0.

Source files
------------

// File: rtl/definitions.sv
// Shared opcodes, FSM states, decode bundle and IR field positions for the
// 9-bit RISC CPU controller.
package definitions;

    localparam logic [2:0] kADD = 3'b000;
    localparam logic [2:0] kAND = 3'b001;
    localparam logic [2:0] kXOR = 3'b010;
    localparam logic [2:0] kLSH = 3'b011;
    localparam logic [2:0] kSTR = 3'b100;
    localparam logic [2:0] kLDI = 3'b101;
    localparam logic [2:0] kBNE = 3'b110;
    localparam logic [2:0] kHLT = 3'b111;

    localparam int OP_MSB    = 8;
    localparam int OP_LSB    = 6;
    localparam int RA_MSB    = 5;
    localparam int RA_LSB    = 3;
    localparam int RB_MSB    = 2;
    localparam int RB_LSB    = 0;
    localparam int IMM_MSB   = 5;
    localparam int SHR_BIT   = 2;
    localparam int SHAMT_MSB = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_e;

    typedef enum logic [1:0] {
        BSEL_ZERO,
        BSEL_RF,
        BSEL_SHAMT,
        BSEL_IMM
    } bsel_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       rsh;
        logic       a_rf;
        bsel_e      b_sel;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       rf_we_req;
        logic       dmem_we_req;
        logic       is_add;
        logic       is_bne;
        logic       is_hlt;
    } dec_t;

    function automatic logic [31:0] sext6(input logic [5:0] v);
        return {{26{v[5]}}, v};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational IR decoder: ALU controls, operand selects and write requests.
// LDI and BNE rewrite the register addresses to their fixed R0/R1 operands.
module instr_decode
    import definitions::*;
(
    input  logic [8:0] ir_i,
    output dec_t       dec_o
);

    logic [2:0] op;

    assign op = ir_i[OP_MSB:OP_LSB];

    always_comb begin
        dec_o        = '0;
        dec_o.alu_op = op;
        dec_o.ra     = ir_i[RA_MSB:RA_LSB];
        dec_o.rb     = ir_i[RB_MSB:RB_LSB];
        unique case (op)
            kADD: begin
                dec_o.a_rf      = 1'b1;
                dec_o.b_sel     = BSEL_RF;
                dec_o.rf_we_req = 1'b1;
                dec_o.is_add    = 1'b1;
            end
            kAND, kXOR: begin
                dec_o.a_rf      = 1'b1;
                dec_o.b_sel     = BSEL_RF;
                dec_o.rf_we_req = 1'b1;
            end
            kLSH: begin
                dec_o.a_rf      = 1'b1;
                dec_o.b_sel     = BSEL_SHAMT;
                dec_o.rsh       = ir_i[SHR_BIT];
                dec_o.rf_we_req = 1'b1;
            end
            kSTR: begin
                dec_o.a_rf        = 1'b1;
                dec_o.dmem_we_req = 1'b1;
            end
            kLDI: begin
                dec_o.b_sel     = BSEL_IMM;
                dec_o.ra        = 3'd0;
                dec_o.rf_we_req = 1'b1;
            end
            kBNE: begin
                dec_o.a_rf   = 1'b1;
                dec_o.b_sel  = BSEL_RF;
                dec_o.ra     = 3'd0;
                dec_o.rb     = 3'd1;
                dec_o.is_bne = 1'b1;
            end
            kHLT: dec_o.is_hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// 4-cycle fetch/decode/execute/writeback controller for the 9-bit RISC CPU.
// Define ALU_CTRL_ADC_EN to feed c_flag into ADD as carry-in (cleared on start).
module alu_ctrl_seq
    import definitions::*;
#(
    parameter int unsigned     PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [2:0]      rf_ra_addr,
    output logic [2:0]      rf_rb_addr,
    input  logic [7:0]      rf_a_data,
    input  logic [7:0]      rf_b_data,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic [7:0]      rf_wdata,
    output logic [2:0]      alu_op,
    output logic            alu_rsh,
    output logic            alu_ci,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    input  logic [7:0]      alu_rslt,
    input  logic            alu_co,
    input  logic            alu_z,
    output logic            dmem_we,
    output logic [7:0]      dmem_addr,
    output logic [7:0]      dmem_wdata
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, br_off;
    logic [8:0]      ir_q, ir_d, ir_src;
    logic            c_flag_q, c_flag_d;
    logic            z_q, z_d;
    logic [7:0]      res_q, res_d;
    logic [7:0]      sa_q, sa_d;
    logic            adc_ci;
    dec_t            dec;

    // In DECODE the fresh ROM word is decoded so rf addresses lead EXEC.
    assign ir_src = (state_q == DECODE) ? imem_data : ir_q;

    instr_decode u_dec (
        .ir_i  (ir_src),
        .dec_o (dec)
    );

    assign br_off = PC_W'(sext6(ir_q[IMM_MSB:0]));

`ifdef ALU_CTRL_ADC_EN
    assign adc_ci = dec.is_add & c_flag_q;
`else
    assign adc_ci = 1'b0;
`endif

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        imem_addr  = '0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        alu_op     = '0;
        alu_rsh    = 1'b0;
        alu_ci     = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        busy = (state_q == FETCH) || (state_q == DECODE) ||
               (state_q == EXEC)  || (state_q == WB);
        done = (state_q == HALT);
        if (state_q == FETCH) begin
            imem_addr = pc_q;
        end
        if (state_q == DECODE || state_q == EXEC) begin
            rf_ra_addr = dec.ra;
            rf_rb_addr = dec.rb;
        end
        if (state_q == EXEC) begin
            alu_op  = dec.alu_op;
            alu_rsh = dec.rsh;
            alu_ci  = adc_ci;
            alu_a   = dec.a_rf ? rf_a_data : 8'd0;
            unique case (dec.b_sel)
                BSEL_RF:    alu_b = rf_b_data;
                BSEL_SHAMT: alu_b = {6'b0, ir_src[SHAMT_MSB:0]};
                BSEL_IMM:   alu_b = {2'b0, ir_src[IMM_MSB:0]};
                default:    alu_b = '0;
            endcase
        end
        if (state_q == WB && dec.rf_we_req) begin
            rf_we    = 1'b1;
            rf_waddr = dec.ra;
            rf_wdata = res_q;
        end
        if (state_q == WB && dec.dmem_we_req) begin
            dmem_we    = 1'b1;
            dmem_addr  = sa_q;
            dmem_wdata = res_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        c_flag_d = c_flag_q;
        z_d      = z_q;
        res_d    = res_q;
        sa_d     = sa_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RST_PC;
`ifdef ALU_CTRL_ADC_EN
                    c_flag_d = 1'b0;
`endif
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                ir_d    = imem_data;
                state_d = EXEC;
            end
            EXEC: begin
                res_d = alu_rslt;
                z_d   = alu_z;
                sa_d  = rf_b_data;
                if (dec.is_add) begin
                    c_flag_d = alu_co;
                end
                state_d = WB;
            end
            WB: begin
                if (dec.is_hlt) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                    if (dec.is_bne && !z_q) begin
                        pc_d = pc_q + br_off;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RST_PC;
            ir_q     <= '0;
            c_flag_q <= 1'b0;
            z_q      <= 1'b0;
            res_q    <= '0;
            sa_q     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            c_flag_q <= c_flag_d;
            z_q      <= z_d;
            res_q    <= res_d;
            sa_q     <= sa_d;
        end
    end

endmodule
